// File: rtl/unidad_control_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
// unidad_control_multiciclo_pkg
// Shared encodings for the multicycle RV32I control unit and its datapath.
// Revision: 1.0
// ============================================================================
package unidad_control_multiciclo_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] INM_I = 2'b00;
  localparam logic [1:0] INM_S = 2'b01;
  localparam logic [1:0] INM_B = 2'b10;
  localparam logic [1:0] INM_J = 2'b11;

  localparam logic [1:0] RES_ALUREG = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic [1:0] inm_src_of(input logic [6:0] opcode);
    case (opcode)
      OP_SW:   return INM_S;
      OP_BEQ:  return INM_B;
      OP_JAL:  return INM_J;
      default: return INM_I;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/unidad_control_multiciclo_decodificador_alu.sv
`default_nettype none
// ============================================================================
// decodificador_alu
// Maps the FSM's coarse ALU request plus funct fields to an ALU operation.
// Revision: 1.0
// ============================================================================
module decodificador_alu
  import unidad_control_multiciclo_pkg::*;
(
  input  logic [1:0] aluOp,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  input  logic       op5,
  output logic [2:0] aluControl
);

  always_comb begin
    aluControl = ALU_ADD;
    case (aluOp)
      ALUOP_SUB:   aluControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type may subtract; addi with imm bit 10 set must still add.
          3'b000:  aluControl = (op5 && f7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  aluControl = ALU_SLT;
          3'b110:  aluControl = ALU_OR;
          3'b111:  aluControl = ALU_AND;
          default: aluControl = ALU_ADD;
        endcase
      end
      default:     aluControl = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/unidad_control_multiciclo.sv
`default_nettype none
// ============================================================================
// unidad_control_multiciclo
// Multicycle RV32I control FSM with a retired-instruction counter.
// Revision: 1.0
// ============================================================================
module unidad_control_multiciclo
  import unidad_control_multiciclo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        zero,
  output logic        pcWrite,
  output logic        adrSrc,
  output logic        memWrite,
  output logic        irWrite,
  output logic        regWrite,
  output logic [1:0]  resultSrc,
  output logic [1:0]  aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [2:0]  aluControl,
  output logic [1:0]  inmSrc,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  logic        pc_update, branch, retire;
  logic [1:0]  alu_op;
  logic [6:0]  opcode;
  logic        unused_inst;

  assign opcode      = inst[6:0];
  assign unused_inst = ^{inst[31], inst[29:15], inst[11:7]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_update = 1'b0;
    branch    = 1'b0;
    retire    = 1'b0;
    adrSrc    = 1'b0;
    memWrite  = 1'b0;
    irWrite   = 1'b0;
    regWrite  = 1'b0;
    illegal   = 1'b0;
    resultSrc = RES_ALUREG;
    aluSrcA   = SRCA_PC;
    aluSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        irWrite   = 1'b1;
        aluSrcB   = SRCB_FOUR;
        resultSrc = RES_ALU;
        pc_update = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        aluSrcA = SRCA_OLDPC;
        aluSrcB = SRCB_IMM;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        resultSrc = RES_MEM;
        regWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        adrSrc   = 1'b1;
        memWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_EXECR: begin
        aluSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        aluSrcA = SRCA_RD1;
        aluSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BEQ: begin
        aluSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL: begin
        aluSrcA   = SRCA_OLDPC;
        aluSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset shows FETCH selects but suppresses every write and the retire.
    if (rst) begin
      state_d   = S_FETCH;
      pc_update = 1'b0;
      branch    = 1'b0;
      retire    = 1'b0;
      adrSrc    = 1'b0;
      memWrite  = 1'b0;
      irWrite   = 1'b0;
      regWrite  = 1'b0;
      illegal   = 1'b0;
      resultSrc = RES_ALU;
      aluSrcA   = SRCA_PC;
      aluSrcB   = SRCB_FOUR;
      alu_op    = ALUOP_ADD;
    end
  end

  assign instret_d = instret_q + {31'd0, retire};
  assign instret   = instret_q;
  assign pcWrite   = pc_update | (branch & zero);
  assign inmSrc    = inm_src_of(opcode);

  decodificador_alu u_decodificador_alu (
    .aluOp      (alu_op),
    .funct3     (inst[14:12]),
    .f7b5       (inst[30]),
    .op5        (opcode[5]),
    .aluControl (aluControl)
  );

endmodule
`default_nettype wire

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Multicycle control unit: the controlling end of the datapath's control/instruction interface. It consumes the fetched instruction and the ALU zero flag and sequences the shared-memory multicycle RV32I datapath through fetch, decode, execute, memory and writeback, one state per clock. It drives every datapath enable and select, and keeps a retired-instruction counter for bring-up and debug.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- inst  in  32  instruction register contents; stable from the cycle after FETCH until the next FETCH.
- zero  in  1  ALU result == 0, from the datapath.
- pcWrite  out  1  PC load enable; equals pcUpdate | (branch & zero).
- adrSrc  out  1  memory address select: 0 = PC, 1 = ALU result register.
- memWrite  out  1  data memory write enable.
- irWrite  out  1  instruction register load enable.
- regWrite  out  1  register bank write enable.
- resultSrc  out  2  result select: 00 = ALU register, 01 = memory data, 10 = ALU result.
- aluSrcA  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rd1.
- aluSrcB  out  2  ALU B select: 00 = rd2, 01 = immediate, 10 = constant 4.
- aluControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- inmSrc  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- instret  out  32  count of retired instructions.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluOp add, resultSrc=10, pcUpdate=1. Next state is DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, add; this computes the branch target.
  - lw (0000011) or sw (0100011) -> MEMADR.
  - R-type (0110011) -> EXECR.
  - I-ALU (0010011) -> EXECI.
  - beq (1100011) -> BEQ.
  - jal (1101111) -> JAL.
  - Any other opcode: pulse illegal, go to FETCH, and do not increment instret.
- MEMADR: aluSrcA=10, aluSrcB=01, add. Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrSrc=1, resultSrc=00, then MEMWB. MEMWB: resultSrc=01, regWrite=1, then FETCH.
- MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1, then FETCH.
- EXECR: aluSrcA=10, aluSrcB=00, aluOp funct, then ALUWB.
- EXECI: aluSrcA=10, aluSrcB=01, aluOp funct, then ALUWB.
- ALUWB: resultSrc=00, regWrite=1, then FETCH.
- BEQ: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, branch=1, then FETCH.
- JAL: aluSrcA=01, aluSrcB=10, add, resultSrc=00, pcUpdate=1, then ALUWB.
- aluOp decode, with funct3 = inst[14:12] and f7b5 = inst[30]:
  - 000 -> sub when R-type and f7b5=1, else add.
  - 010 -> slt.
  - 110 -> or.
  - 111 -> and.
  - Other funct3 -> add.
- inmSrc is decoded from the opcode in every state: I for lw and I-ALU, S for sw, B for beq, J for jal, 00 otherwise.
- Outputs are Moore functions of state; aluControl and inmSrc additionally depend on inst.
- instret increments on the final state of each instruction (MEMWB, MEMWRITE, ALUWB, BEQ). It wraps 0xFFFFFFFF -> 0.

## Timing
- Cycles per instruction: lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Reset:
  - A cycle sampled with rst=1 puts the state in FETCH and clears instret to 0.
  - While rst=1, all enables (pcWrite, irWrite, regWrite, memWrite) and illegal are forced to 0; selects show their FETCH values.
  - Reset asserted mid-instruction aborts it with no further writes and no instret increment.
- The first FETCH occurs in the cycle after rst deasserts.
- beq: pcWrite is asserted in the BEQ cycle only if zero=1 in that same cycle.
- There is no stall input; every state lasts exactly one cycle.

## Structure
- Shared package: the state enum, opcode localparams, ALU control codes, and the inmSrc/resultSrc/aluSrc encodings. The datapath uses the same encodings.
- One sub-module, decodificador_alu (combinational): inputs aluOp[1:0], funct3, f7b5 and opcode bit 5; output aluControl.
- The FSM and the instret register live in the top module.

## Test plan
- Reset: rst high for 2 cycles -> all enables 0, instret=0. First cycle after release: irWrite=1 and pcWrite=1.
- lw x5,8(x0) = 0x00802283:
  - State sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - regWrite=1 with resultSrc=01 in cycle 5; inmSrc=00 throughout.
  - instret goes 0 -> 1.
- sw x5,4(x0) = 0x00502223 -> memWrite=1 only in cycle 4, inmSrc=01, regWrite never asserted.
- add x3,x1,x2 = 0x002081B3, then sub x3,x1,x2 = 0x402081B3 -> aluControl=000, then 001, in the respective EXECR cycles; both complete in 4 cycles each.
- beq x0,x0,8 = 0x00000463 -> pcWrite=1 in cycle 3 with zero=1. Repeated with zero=0: pcWrite=0. inmSrc=10 in both runs.
- Illegal and abort cases:
  - inst=0x00000000 -> illegal pulse in the DECODE cycle, back to FETCH, instret unchanged.
  - jal x1,16 = 0x010000EF with rst asserted in its JAL cycle -> no regWrite, instret unchanged, next state FETCH.
